// File: rtl/babbage_root_if.sv
// Request/result bus of babbage_root: coefficients and target in, root plus flags out.
// Pulse-in/pulse-out handshake: y_val is honoured only while ready is high, and valid pulses for one cycle.
interface babbage_root_if #(
    parameter int XW = 8,
    parameter int CW = 8,
    parameter int YW = 33
);
    logic [CW-1:0] a3;
    logic [CW-1:0] a2;
    logic [CW-1:0] a1;
    logic [CW-1:0] a0;
    logic [YW-1:0] y;
    logic          y_val;
    logic          ready;
    logic          valid;
    logic [XW-1:0] x;
    logic          exact;
    logic          under;

    modport master (
        output a3, a2, a1, a0, y, y_val,
        input  ready, valid, x, exact, under
    );

    modport slave (
        input  a3, a2, a1, a0, y, y_val,
        output ready, valid, x, exact, under
    );
endinterface

// File: rtl/babbage_root.sv
// Largest x with a3*x^3+a2*x^2+a1*x+a0 <= y: MSB-first bit search over a sequential Horner evaluator.
// Fixed latency of 4*XW edges; ready is low while busy. Macro BABBAGE_ROOT_RESTART_EN lets y_val abort and restart a search.
module babbage_root #(
    parameter int XW = 8,
    parameter int CW = 8,
    parameter int YW = 33
) (
    input  logic           clk,
    input  logic           rst,
    babbage_root_if.slave  bus
);
    localparam int BW = (XW > 1) ? $clog2(XW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        CMP  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_capture;

    logic [CW-1:0] r_a3;
    logic [CW-1:0] r_a2;
    logic [CW-1:0] r_a1;
    logic [CW-1:0] r_a0;
    logic [YW-1:0] r_y;
    logic [YW-1:0] r_acc;
    logic [XW-1:0] r_trial;
    logic [XW-1:0] r_x_acc;
    logic [BW-1:0] r_b;
    logic [1:0]    r_step;
    logic          r_exact;
    logic          r_under;

    logic          r_valid;
    logic [XW-1:0] r_x_out;
    logic          r_exact_out;
    logic          r_under_out;

    logic [YW-1:0] w_coef;
    logic [YW-1:0] w_horner;
    logic          w_fit;
    logic          w_exact_nxt;
    logic [XW-1:0] w_x_new;
    logic [BW-1:0] w_b_dec;
    logic [XW-1:0] w_trial_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.y_val) begin
                    w_capture   = 1'b1;
                    w_state_nxt = EVAL;
                end
            end
            EVAL:    w_state_nxt = (r_step == 2'd2) ? CMP : EVAL;
            CMP:     w_state_nxt = (r_b == '0) ? IDLE : EVAL;
            default: w_state_nxt = IDLE;
        endcase
`ifdef BABBAGE_ROOT_RESTART_EN
        if (r_state != IDLE && bus.y_val) begin
            w_capture   = 1'b1;
            w_state_nxt = EVAL;
        end
`endif
    end

    // Horner step: acc*trial + next lower coefficient
    always_comb begin
        case (r_step)
            2'd0:    w_coef = YW'(r_a2);
            2'd1:    w_coef = YW'(r_a1);
            default: w_coef = YW'(r_a0);
        endcase
        w_horner    = r_acc * YW'(r_trial) + w_coef;
        w_fit       = (r_acc <= r_y);
        w_exact_nxt = r_exact | (w_fit && (r_acc == r_y));
        w_x_new     = w_fit ? r_trial : r_x_acc;
        w_b_dec     = r_b - BW'(1);
        w_trial_nxt = w_x_new | (XW'(1) << w_b_dec);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a3        <= '0;
            r_a2        <= '0;
            r_a1        <= '0;
            r_a0        <= '0;
            r_y         <= '0;
            r_acc       <= '0;
            r_trial     <= '0;
            r_x_acc     <= '0;
            r_b         <= '0;
            r_step      <= '0;
            r_exact     <= 1'b0;
            r_under     <= 1'b0;
            r_valid     <= 1'b0;
            r_x_out     <= '0;
            r_exact_out <= 1'b0;
            r_under_out <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_capture) begin
                r_a3    <= bus.a3;
                r_a2    <= bus.a2;
                r_a1    <= bus.a1;
                r_a0    <= bus.a0;
                r_y     <= bus.y;
                r_acc   <= YW'(bus.a3);
                r_trial <= XW'(1) << (XW - 1);
                r_x_acc <= '0;
                r_b     <= BW'(XW - 1);
                r_step  <= 2'd0;
                r_exact <= (YW'(bus.a0) == bus.y);
                r_under <= (YW'(bus.a0) > bus.y);
            end else begin
                case (r_state)
                    EVAL: begin
                        r_acc  <= w_horner;
                        r_step <= r_step + 2'd1;
                    end
                    CMP: begin
                        r_x_acc <= w_x_new;
                        r_exact <= w_exact_nxt;
                        r_step  <= 2'd0;
                        if (r_b != '0) begin
                            r_b     <= w_b_dec;
                            r_trial <= w_trial_nxt;
                            r_acc   <= YW'(r_a3);
                        end else begin
                            r_valid     <= 1'b1;
                            r_x_out     <= r_under ? '0 : w_x_new;
                            r_exact_out <= ~r_under & w_exact_nxt;
                            r_under_out <= r_under;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.ready = (r_state == IDLE);
    assign bus.valid = r_valid;
    assign bus.x     = r_x_out;
    assign bus.exact = r_exact_out;
    assign bus.under = r_under_out;
endmodule

// File: tb/tb_babbage_root.sv
// Bench for babbage_root: directed vectors, randomized requests against an exhaustive-search model, busy/reset scenarios.
module tb_babbage_root;
    localparam int XW  = 8;
    localparam int CW  = 8;
    localparam int YW  = 33;
    localparam int LAT = 4 * XW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    babbage_root_if #(.XW(XW), .CW(CW), .YW(YW)) bus ();
    babbage_root #(.XW(XW), .CW(CW), .YW(YW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int edges  = 0;
    int cap_edge = 0;
    int val_edge = 0;

    always @(posedge clk) edges <= edges + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    function automatic longint unsigned poly(input longint unsigned c3, c2, c1, c0, xx);
        return c3 * xx * xx * xx + c2 * xx * xx + c1 * xx + c0;
    endfunction

    // Exhaustive search for the greatest x with p(x) <= y
    task automatic model(input logic [CW-1:0] c3, c2, c1, c0, input logic [YW-1:0] yy,
                         output logic [XW-1:0] ex, output logic ee, output logic eu);
        eu = (c0 > yy);
        ex = '0;
        ee = 1'b0;
        if (!eu) begin
            for (int v = 0; v < (1 << XW); v++)
                if (poly(c3, c2, c1, c0, v) <= yy) ex = v[XW-1:0];
            ee = (poly(c3, c2, c1, c0, longint'(ex)) == yy);
        end
    endtask

    task automatic start_req(input logic [CW-1:0] c3, c2, c1, c0, input logic [YW-1:0] yy);
        bus.a3 = c3; bus.a2 = c2; bus.a1 = c1; bus.a0 = c0; bus.y = yy;
        bus.y_val = 1'b1;
        @(posedge clk);
        #1;
        cap_edge  = edges;
        bus.y_val = 1'b0;
    endtask

    task automatic do_req(input string nm, input logic [CW-1:0] c3, c2, c1, c0, input logic [YW-1:0] yy);
        logic [XW-1:0] ex;
        logic ee, eu;
        int lat;
        bit rdy_bad;
        model(c3, c2, c1, c0, yy, ex, ee, eu);
        start_req(c3, c2, c1, c0, yy);
        lat = -1;
        rdy_bad = 0;
        for (int n = 1; n <= LAT + 8; n++) begin
            @(posedge clk);
            #1;
            if (n < LAT && bus.ready !== 1'b0) rdy_bad = 1;
            if (bus.valid === 1'b1) begin
                lat = n;
                val_edge = edges;
                break;
            end
        end
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, expected %0d", nm, lat, LAT);
        end
        checks++;
        if (rdy_bad || bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready: busy-high=%0d ready-at-result=%b, expected 0 and 1", nm, rdy_bad, bus.ready);
        end
        checks++;
        if (bus.x !== ex) begin
            errors++;
            $display("FAIL %s x: got %0d, expected %0d", nm, bus.x, ex);
        end
        checks++;
        if (bus.exact !== ee) begin
            errors++;
            $display("FAIL %s exact: got %b, expected %b", nm, bus.exact, ee);
        end
        checks++;
        if (bus.under !== eu) begin
            errors++;
            $display("FAIL %s under: got %b, expected %b", nm, bus.under, eu);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (bus.ready !== 1'b1 || bus.valid !== 1'b0 || bus.x !== '0 || bus.exact !== 1'b0 || bus.under !== 1'b0) begin
            errors++;
            $display("FAIL reset: ready=%b valid=%b x=%0d exact=%b under=%b, expected 1 0 0 0 0",
                     bus.ready, bus.valid, bus.x, bus.exact, bus.under);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_req("cube27", 8'd1, 8'd0, 8'd0, 8'd0, 33'd27);
        @(posedge clk);
        #1;
        checks++;
        if (bus.valid !== 1'b0 || bus.x !== 8'd3) begin
            errors++;
            $display("FAIL pulse_width: valid=%b x=%0d one cycle later, expected 0 and held 3", bus.valid, bus.x);
        end
        do_req("cube26", 8'd1, 8'd0, 8'd0, 8'd0, 33'd26);
        do_req("under", 8'd1, 8'd1, 8'd1, 8'd10, 33'd9);
        do_req("max_exact", 8'd255, 8'd255, 8'd255, 8'd255, 33'd4244897280);
        do_req("max_minus1", 8'd255, 8'd255, 8'd255, 8'd255, 33'd4244897279);
        do_req("zero_poly", 8'd0, 8'd0, 8'd0, 8'd0, 33'd0);
    endtask

    task automatic test_back_to_back();
        int first_cap, first_val;
        do_req("flat7", 8'd0, 8'd0, 8'd0, 8'd7, 33'd7);
        first_cap = cap_edge;
        first_val = val_edge;
        do_req("b2b_second", 8'd1, 8'd0, 8'd0, 8'd0, 33'd27);
        checks++;
        if (cap_edge - first_cap !== LAT + 1 || val_edge - first_cap !== 2 * LAT + 1) begin
            errors++;
            $display("FAIL back_to_back: capture at E%0d result at E%0d, expected E%0d and E%0d",
                     cap_edge - first_cap, val_edge - first_cap, LAT + 1, 2 * LAT + 1);
        end
        checks++;
        if (first_val - first_cap !== LAT) begin
            errors++;
            $display("FAIL b2b_first_edge: result at E%0d, expected E%0d", first_val - first_cap, LAT);
        end
    endtask

    task automatic test_busy_request();
        int pulses, first_n;
        logic [XW-1:0] fx;
        logic fe;
        int exp_n;
        logic [XW-1:0] exp_x;
        start_req(8'd1, 8'd0, 8'd0, 8'd0, 33'd27);
        repeat (9) @(posedge clk);
        #1;
        bus.a3 = 8'd1; bus.a2 = 8'd0; bus.a1 = 8'd0; bus.a0 = 8'd0; bus.y = 33'd8;
        bus.y_val = 1'b1;
        @(posedge clk);
        #1;
        bus.y_val = 1'b0;
        pulses = 0;
        first_n = -1;
        fx = '0;
        fe = 1'b0;
        for (int n = 11; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (bus.valid === 1'b1) begin
                pulses++;
                if (first_n < 0) begin
                    first_n = n;
                    fx = bus.x;
                    fe = bus.exact;
                end
            end
        end
`ifdef BABBAGE_ROOT_RESTART_EN
        exp_n = 10 + LAT;
        exp_x = 8'd2;
`else
        exp_n = LAT;
        exp_x = 8'd3;
`endif
        checks++;
        if (pulses !== 1 || first_n !== exp_n) begin
            errors++;
            $display("FAIL busy_request timing: %0d pulses first at E%0d, expected 1 at E%0d", pulses, first_n, exp_n);
        end
        checks++;
        if (fx !== exp_x || fe !== 1'b1) begin
            errors++;
            $display("FAIL busy_request result: x=%0d exact=%b, expected x=%0d exact=1", fx, fe, exp_x);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        start_req(8'd1, 8'd0, 8'd0, 8'd0, 33'd27);
        repeat (10) @(posedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.ready !== 1'b1 || bus.valid !== 1'b0 || bus.x !== '0 || bus.exact !== 1'b0 || bus.under !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: ready=%b valid=%b x=%0d exact=%b under=%b, expected 1 0 0 0 0",
                     bus.ready, bus.valid, bus.x, bus.exact, bus.under);
        end
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int n = 0; n < LAT + 10; n++) begin
            @(posedge clk);
            #1;
            if (bus.valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_after: pulses=%0d ready=%b, expected 0 and 1", pulses, bus.ready);
        end
    endtask

    task automatic test_random();
        logic [CW-1:0] c3, c2, c1, c0;
        longint unsigned yl, pv;
        int rx;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                c3 = CW'($urandom_range(0, 3)); c2 = CW'($urandom_range(0, 3));
                c1 = CW'($urandom_range(0, 3)); c0 = CW'($urandom_range(0, 3));
            end else begin
                c3 = CW'($urandom); c2 = CW'($urandom); c1 = CW'($urandom); c0 = CW'($urandom);
            end
            rx = $urandom_range(0, (1 << XW) - 1);
            pv = poly(c3, c2, c1, c0, longint'(rx));
            case ($urandom_range(0, 3))
                0: yl = pv + longint'($urandom_range(0, 1));
                1: yl = (pv > 0) ? pv - 1 : pv;
                2: yl = ((longint'($urandom) << 1) | longint'($urandom_range(0, 1)));
                default: yl = (c0 > 0) ? longint'($urandom_range(0, int'(c0) - 1)) : pv;
            endcase
            do_req($sformatf("rand%0d", i), c3, c2, c1, c0, yl[YW-1:0]);
        end
    endtask

    initial begin
        bus.a3 = '0; bus.a2 = '0; bus.a1 = '0; bus.a0 = '0;
        bus.y = '0; bus.y_val = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_busy_request();
        repeat (40) @(posedge clk);
        #1;
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
